// File: rtl/alu_op_pkg.sv
// Shared types and the combinational RV32I-to-ALU decode used by alu_op_decoder.
package alu_op_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SLT = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e         operation;
    logic            src_b_imm;
    logic [XLEN-1:0] imm;
    logic            branch;
    logic            br_invert;
    logic            illegal;
  } decoded_t;

  // funct3 to operation for the register/immediate arithmetic group; alt is instr[30].
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:         op = alt ? ALU_SUB : ALU_ADD;
      3'b001:         op = ALU_SLL;
      3'b010, 3'b011: op = ALU_SLT;
      3'b100:         op = ALU_XOR;
      3'b101:         op = alt ? ALU_SRA : ALU_SRL;
      3'b110:         op = ALU_OR;
      default:        op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decoded_t decode(input logic [XLEN-1:0] instr);
    decoded_t        d;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            bad;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] shamt;

    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    // Shift-immediates carry only the shift amount, not funct7 bits.
    shamt = {27'd0, instr[24:20]};
    d     = '0;
    bad   = 1'b0;

    case (opc)
      OPC_OP: begin
        d.operation = arith_op(f3, instr[30]);
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        d.src_b_imm = 1'b1;
        d.imm       = imm_i;
        case (f3)
          3'b001: begin
            d.operation = ALU_SLL;
            d.imm       = shamt;
            bad         = (f7 != 7'h00);
          end
          3'b101: begin
            d.operation = instr[30] ? ALU_SRA : ALU_SRL;
            d.imm       = shamt;
            bad         = !((f7 == 7'h00) || (f7 == 7'h20));
          end
          default: d.operation = arith_op(f3, 1'b0);
        endcase
      end
      OPC_LOAD: begin
        d.src_b_imm = 1'b1;
        d.imm       = imm_i;
      end
      OPC_STORE: begin
        d.src_b_imm = 1'b1;
        d.imm       = imm_s;
      end
      OPC_BRANCH: begin
        d.branch = 1'b1;
        d.imm    = imm_b;
        case (f3)
          3'b000:         d.operation = ALU_EQ;
          3'b001: begin
            d.operation = ALU_EQ;
            d.br_invert = 1'b1;
          end
          3'b100, 3'b110: d.operation = ALU_SLT;
          3'b101, 3'b111: begin
            d.operation = ALU_SLT;
            d.br_invert = 1'b1;
          end
          default:        bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / decoded-fields-out valid/ready bundle for alu_op_decoder.
interface alu_op_decoder_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] out_operation;
  logic                     out_src_b_imm;
  logic [DATA_WIDTH-1:0]    out_imm;
  logic                     out_branch;
  logic                     out_br_invert;
  logic                     out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_operation, out_src_b_imm, out_imm,
           out_branch, out_br_invert, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_operation, out_src_b_imm, out_imm,
           out_branch, out_br_invert, out_illegal
  );
endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer: main entry drives the output,
// skid entry catches one word while the output is stalled; in_ready is registered.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_MAIN  = 2'b01,
    S_FULL  = 2'b10
  } occ_e;

  occ_e             state_q;
  occ_e             state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             load_skid;
  logic             move_skid;

  assign in_ready  = rst_n && (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d   = S_MAIN;
          load_main = 1'b1;
        end
      end
      S_MAIN: begin
        // Pop and accept together keeps one entry: the new word replaces main.
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d   = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          state_d   = S_MAIN;
          move_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_data;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I decode stage feeding the ALU: combinational decode of the incoming
// instruction, registered through a 2-entry skid buffer toward EX.
module alu_op_decoder
  import alu_op_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_op_decoder_if.slave  bus
);

  decoded_t dec_in;
  decoded_t dec_out;

  assign dec_in = decode(XLEN'(bus.in_instr));

  skid_buffer #(
    .WIDTH($bits(decoded_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (dec_out)
  );

  assign bus.out_operation = OPCODE_LENGTH'(dec_out.operation);
  assign bus.out_src_b_imm = dec_out.src_b_imm;
  assign bus.out_imm       = DATA_WIDTH'(dec_out.imm);
  assign bus.out_branch    = dec_out.branch;
  assign bus.out_br_invert = dec_out.br_invert;
  assign bus.out_illegal   = dec_out.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: expected decodes queued on input
// handshake, popped and compared on output handshake.
module tb_alu_op_decoder;
  import alu_op_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_decoder_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_op_decoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int       checks   = 0;
  int       failures = 0;
  decoded_t exp_q[$];

  localparam decoded_t ILL = '{ALU_ADD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1};

  function automatic decoded_t observed();
    decoded_t o;
    o.operation = alu_op_e'(bus.out_operation);
    o.src_b_imm = bus.out_src_b_imm;
    o.imm       = bus.out_imm;
    o.branch    = bus.out_branch;
    o.br_invert = bus.out_br_invert;
    o.illegal   = bus.out_illegal;
    return o;
  endfunction

  // Reference decode, organised by mnemonic rather than by field.
  function automatic decoded_t ref_decode(input logic [31:0] w);
    decoded_t   r;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    f7 = w[31:25];
    f3 = w[14:12];
    r  = '{ALU_ADD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    ok = 1'b1;
    if (w[6:0] == 7'h33) begin
      case ({f7, f3})
        {7'h00, 3'd0}: r.operation = ALU_ADD;
        {7'h20, 3'd0}: r.operation = ALU_SUB;
        {7'h00, 3'd1}: r.operation = ALU_SLL;
        {7'h00, 3'd2}: r.operation = ALU_SLT;
        {7'h00, 3'd3}: r.operation = ALU_SLT;
        {7'h00, 3'd4}: r.operation = ALU_XOR;
        {7'h00, 3'd5}: r.operation = ALU_SRL;
        {7'h20, 3'd5}: r.operation = ALU_SRA;
        {7'h00, 3'd6}: r.operation = ALU_OR;
        {7'h00, 3'd7}: r.operation = ALU_AND;
        default:       ok = 1'b0;
      endcase
    end else if (w[6:0] == 7'h13) begin
      r.src_b_imm = 1'b1;
      r.imm       = 32'($signed(w[31:20]));
      case (f3)
        3'd0: r.operation = ALU_ADD;
        3'd2, 3'd3: r.operation = ALU_SLT;
        3'd4: r.operation = ALU_XOR;
        3'd6: r.operation = ALU_OR;
        3'd7: r.operation = ALU_AND;
        3'd1: begin
          r.operation = ALU_SLL;
          r.imm = {27'd0, w[24:20]};
          if (f7 != 7'h00) ok = 1'b0;
        end
        default: begin
          r.imm = {27'd0, w[24:20]};
          if (f7 == 7'h00) r.operation = ALU_SRL;
          else if (f7 == 7'h20) r.operation = ALU_SRA;
          else ok = 1'b0;
        end
      endcase
    end else if (w[6:0] == 7'h03) begin
      r.src_b_imm = 1'b1;
      r.imm = 32'($signed(w[31:20]));
    end else if (w[6:0] == 7'h23) begin
      r.src_b_imm = 1'b1;
      r.imm = 32'($signed({w[31:25], w[11:7]}));
    end else if (w[6:0] == 7'h63) begin
      r.branch = 1'b1;
      r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      r.br_invert = f3[0];
      if (f3 == 3'd0 || f3 == 3'd1) r.operation = ALU_EQ;
      else if (f3[2]) r.operation = ALU_SLT;
      else ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) r = ILL;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_ready got out_valid=%b in_ready=%b exp 0 0", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (observed() !== decoded_t'('0)) begin
      failures++;
      $display("FAIL reset_fields got=%h exp=0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] instrs[10];
    decoded_t    exps[10];
    decoded_t    e;
    int          idx = 0;
    instrs = '{32'h003100B3, 32'h403100B3, 32'h40315093, 32'h00209463, 32'hFFFFFFFF,
               32'h02000033, 32'hFFC12083, 32'h00312423, 32'h40311093, 32'h003100B3};
    exps   = '{'{ALU_ADD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0},
               '{ALU_SUB, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0},
               '{ALU_SRA, 1'b1, 32'h3,        1'b0, 1'b0, 1'b0},
               '{ALU_EQ,  1'b0, 32'h8,        1'b1, 1'b1, 1'b0},
               ILL, ILL,
               '{ALU_ADD, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0},
               '{ALU_ADD, 1'b1, 32'h8,        1'b0, 1'b0, 1'b0},
               ILL,
               '{ALU_ADD, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0}};
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 10 || exp_q.size() > 0); c++) begin
      bus.in_valid = (idx < 10);
      bus.in_instr = instrs[(idx < 10) ? idx : 0];
      #1;
      // With out_ready held, each accepted word must be presented the very next cycle.
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL directed_latency got out_valid=%b exp=%b", bus.out_valid, exp_q.size() != 0);
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          failures++;
          $display("FAIL directed_data got=%h exp=%h", observed(), e);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(exps[idx]);
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 10 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL directed_timeout got accepted=%0d pending=%0d exp 10 0", idx, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] instrs[3];
    decoded_t    e;
    int          idx = 0;
    instrs = '{32'h403100B3, 32'h40315093, 32'h00209463};
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (idx < 3);
      bus.in_instr = instrs[(idx < 3) ? idx : 0];
      #1;
      if (c >= 2) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, bus.in_ready);
        end
      end
      if (c >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== ref_decode(instrs[0])) begin
          failures++;
          $display("FAIL bp_stable cycle=%0d got v=%b %h exp v=1 %h", c, bus.out_valid, observed(), ref_decode(instrs[0]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_decode(instrs[idx]));
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != 2) begin
      failures++;
      $display("FAIL bp_accepted got=%0d exp=2", idx);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 3 || exp_q.size() > 0); c++) begin
      bus.in_valid = (idx < 3);
      bus.in_instr = instrs[(idx < 3) ? idx : 0];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra got=%h exp=none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            failures++;
            $display("FAIL bp_order got=%h exp=%h", observed(), e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_decode(instrs[idx]));
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got accepted=%0d pending=%0d exp 3 0", idx, exp_q.size());
    end
  endtask

  task automatic test_random();
    decoded_t e;
    decoded_t prev_obs = '0;
    logic     prev_stall = 1'b0;
    int       sent = 0;
    int       got  = 0;
    bus.in_instr = rand_instr();
    for (int c = 0; c < 3000 && (sent < 200 || exp_q.size() > 0); c++) begin
      bus.in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== prev_obs) begin
          failures++;
          $display("FAIL rand_hold got v=%b %h exp v=1 %h", bus.out_valid, observed(), prev_obs);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_obs   = observed();
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra got=%h exp=none", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            failures++;
            $display("FAIL rand_data got=%h exp=%h", observed(), e);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_decode(bus.in_instr));
        sent++;
        @(negedge clk);
        bus.in_instr = rand_instr();
      end else begin
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (sent != 200 || got != 200 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_count got sent=%0d recv=%0d pending=%0d exp 200 200 0", sent, got, exp_q.size());
    end
  endtask

  task automatic test_reset_full();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00209463;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_setup got in_ready=%b out_valid=%b exp 0 1", bus.in_ready, bus.out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || observed() !== decoded_t'('0)) begin
      failures++;
      $display("FAIL rstfull_clear got v=%b r=%b %h exp 0 0 0", bus.out_valid, bus.in_ready, observed());
    end
    exp_q.delete();
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstfull_release got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
